// File: rtl/cau_pkg.sv
// Shared opcodes, widths and state encodings for the CAU scheduler and its slot timers.
package cau_pkg;

  localparam int CAU_DATA_W = 72;

  localparam logic [1:0] OP_NOOP        = 2'b00;
  localparam logic [1:0] OP_LOAD_SCOPE  = 2'b01;
  localparam logic [1:0] OP_LOAD_KERNEL = 2'b10;
  localparam logic [1:0] OP_CLEAR       = 2'b11;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'b00,
    SLOT_RUN  = 2'b01,
    SLOT_DONE = 2'b10
  } slot_state_e;

  typedef enum logic {
    TOP_INIT = 1'b0,
    TOP_RUN  = 1'b1
  } top_state_e;

  // A single-unit array still needs a 1-bit pointer; it simply never moves.
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cau_slot_timer.sv
// Per-CAU occupancy and convolution-latency countdown: IDLE -> RUN -> DONE -> IDLE.
module cau_slot_timer
  import cau_pkg::*;
#(
  parameter int CONV_LAT = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic drain,
  input  logic flush,
  output logic done,
  output logic idle
);

  localparam int CNT_W = $clog2(CONV_LAT + 1);

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = SLOT_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SLOT_IDLE: begin
          if (start) begin
            state_d = SLOT_RUN;
            cnt_d   = CNT_W'(CONV_LAT);
          end
        end
        SLOT_RUN: begin
          // Leaving RUN on count 1 puts DONE exactly CONV_LAT cycles after the load-scope cycle.
          if (cnt_q == CNT_W'(1)) begin
            state_d = SLOT_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SLOT_DONE: begin
          if (drain) state_d = SLOT_IDLE;
        end
        default: begin
          state_d = SLOT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments make every flop sample its _d value at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done = (state_q == SLOT_DONE);
  assign idle = (state_q == SLOT_IDLE);

endmodule

// File: rtl/cau_scheduler.sv
// Sequences a bank of CAUs: broadcast kernel loads, round-robin window dispatch, in-order results.
module cau_scheduler
  import cau_pkg::*;
#(
  parameter int NUM_CAU  = 4,
  parameter int DATA_W   = CAU_DATA_W,
  parameter int RES_W    = 20,
  parameter int CONV_LAT = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     kern_valid,
  output logic                     kern_ready,
  input  logic [DATA_W-1:0]        kern_data,
  input  logic                     win_valid,
  output logic                     win_ready,
  input  logic [DATA_W-1:0]        win_data,
  output logic [NUM_CAU-1:0]       op_select,
  output logic [1:0]               op_code,
  output logic [DATA_W-1:0]        op_bus,
  input  logic [NUM_CAU*RES_W-1:0] cau_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data,
  output logic                     busy
);

  localparam int               PTR_W    = ptr_width(NUM_CAU);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CAU - 1);

  top_state_e         state_q, state_d;
  logic [NUM_CAU-1:0] sel_q, sel_d;
  logic [1:0]         code_q, code_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [NUM_CAU-1:0] slot_start, slot_drain, slot_done, slot_idle;
  logic               slot_flush;
  logic               all_idle, kern_ready_c, win_ready_c, res_valid_c;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_CAU; i++) begin : g_slot
    cau_slot_timer #(
      .CONV_LAT(CONV_LAT)
    ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .start(slot_start[i]),
      .drain(slot_drain[i]),
      .flush(slot_flush),
      .done (slot_done[i]),
      .idle (slot_idle[i])
    );
  end

  assign all_idle    = &slot_idle;
  assign res_valid_c = slot_done[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    sel_d        = '0;
    code_d       = OP_NOOP;
    bus_d        = '0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    slot_start   = '0;
    slot_drain   = '0;
    slot_flush   = 1'b0;
    kern_ready_c = 1'b0;
    win_ready_c  = 1'b0;

    if (state_q == TOP_INIT) begin
      state_d = TOP_RUN;
      sel_d   = '1;
      code_d  = OP_CLEAR;
    end else if (clear) begin
      sel_d      = '1;
      code_d     = OP_CLEAR;
      slot_flush = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      // A pending kernel holds off new windows so the array drains and the kernel gets in.
      kern_ready_c = !rst && all_idle;
      win_ready_c  = !rst && !kern_valid && slot_idle[wr_ptr_q];

      if (res_valid_c && res_ready) begin
        slot_drain[rd_ptr_q] = 1'b1;
        rd_ptr_d             = ptr_inc(rd_ptr_q);
      end

      if (kern_valid && kern_ready_c) begin
        sel_d  = '1;
        code_d = OP_LOAD_KERNEL;
        bus_d  = kern_data;
      end else if (win_valid && win_ready_c) begin
        sel_d                = NUM_CAU'(1) << wr_ptr_q;
        code_d               = OP_LOAD_SCOPE;
        bus_d                = win_data;
        slot_start[wr_ptr_q] = 1'b1;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TOP_INIT;
      sel_q    <= '0;
      code_q   <= OP_NOOP;
      bus_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      code_q   <= code_d;
      bus_q    <= bus_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign op_select  = sel_q;
  assign op_code    = code_q;
  assign op_bus     = bus_q;
  assign kern_ready = kern_ready_c;
  assign win_ready  = win_ready_c;
  assign res_valid  = res_valid_c;
  assign res_data   = res_valid_c ? cau_result[int'(rd_ptr_q) * RES_W +: RES_W] : '0;
  assign busy       = rst || (state_q == TOP_INIT) || (code_q == OP_CLEAR) || !all_idle;

endmodule
